// File: rtl/fan_pkg.sv
// Shared fan-control definitions: one-hot fan levels and the duty-cycle
// thresholds (in sixteenths) that separate them.
package fan_pkg;

  // One-hot fan level encoding shared with the fan controller.
  localparam logic [7:0] S_IDLE = 8'b0000_0001;
  localparam logic [7:0] S_1    = 8'b0000_0010;
  localparam logic [7:0] S_2    = 8'b0000_0100;
  localparam logic [7:0] S_3    = 8'b0000_1000;
  localparam logic [7:0] S_4    = 8'b0001_0000;
  localparam logic [7:0] S_5    = 8'b0010_0000;
  localparam logic [7:0] S_6    = 8'b0100_0000;
  localparam logic [7:0] S_7    = 8'b1000_0000;

  // Duty thresholds in sixteenths; element 0 is the lowest threshold.
  localparam int N_THR = 7;
  localparam logic [N_THR-1:0][3:0] THRESHOLDS =
    {4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd1};

  // One-hot encoding of a 0..7 fan level.
  function automatic logic [7:0] level_onehot(input logic [2:0] lvl);
    return 8'b0000_0001 << lvl;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes the asynchronous PWM pin and produces one-cycle rise/fall
// strobes. Defining PWM_CAP_GLITCH_FILTER_EN adds a filter that accepts a
// new level only after 4 consecutive equal samples.
module edge_sync (
  input  logic clk,
  input  logic reset_p,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2 takes the previous s1, giving a real two-stage chain.
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic [1:0] run;

  // Accept a new level only after four consecutive differing samples.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      run   <= 2'd0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        run <= 2'd0;
      end else if (run == 2'd3) begin
        level <= s2;
        rise  <= s2;
        fall  <= ~s2;
        run   <= 2'd0;
      end else begin
        run <= run + 2'd1;
      end
    end
  end
`else
  // Track the synchronized level and strobe on every change.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 != level) begin
        level <= s2;
        rise  <= s2;
        fall  <= ~s2;
      end
    end
  end
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a PWM input in clocks,
// decodes the duty cycle into a one-hot fan level and flags loss of signal.
// Optional macro PWM_CAP_GLITCH_FILTER_EN enables the input glitch filter
// inside edge_sync.
module pwm_capture
  import fan_pkg::*;
#(
  parameter int SYS_FREQ    = 125,        // MHz, informational only
  parameter int W           = 24,
  parameter int TIMEOUT_CYC = 1_250_000
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         pwm_in,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] period_cnt,
  output logic         meas_valid,
  output logic [7:0]   state,
  output logic         timeout
);

  if (TIMEOUT_CYC < 2 || SYS_FREQ < 1) begin : g_param_check
    $error("pwm_capture: TIMEOUT_CYC must be >= 2 and SYS_FREQ >= 1");
  end

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  typedef enum logic {DISARMED, ARMED} meas_state_t;

  logic          level, rise, fall;
  logic [W-1:0]  cnt, high_latch;
  logic [IW-1:0] idle;
  logic          timeout_hit;
  logic          load;
  meas_state_t   meas_q, meas_d;
  logic [2:0]    lvl;
  logic [W+3:0]  high_x16, per_ext, prod;

  edge_sync u_edge_sync (
    .clk     (clk),
    .reset_p (reset_p),
    .pwm_in  (pwm_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  // Idle time reaches the limit this cycle only if no edge arrives with it.
  assign timeout_hit = !(rise || fall) && (idle == IDLE_LAST);

  // Free-running period counter (restarts at 1 on rise) and high-time latch.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt        <= '0;
      high_latch <= '0;
    end else begin
      if (rise)
        cnt <= W'(1);
      else if (cnt != '1)
        cnt <= cnt + W'(1);
      if (fall)
        high_latch <= cnt;
    end
  end

  // Clocks since the last edge of either polarity, saturating at the limit.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      idle <= '0;
    else if (rise || fall)
      idle <= '0;
    else if (idle != IDLE_MAX)
      idle <= idle + IW'(1);
  end

  // Arming state register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      meas_q <= DISARMED;
    else
      meas_q <= meas_d;
  end

  // First rise arms; later rises publish a measurement; timeout disarms.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    meas_d = meas_q;
    load   = 1'b0;
    case (meas_q)
      DISARMED: if (rise) meas_d = ARMED;
      ARMED: begin
        if (rise)
          load = 1'b1;
        else if (timeout_hit)
          meas_d = DISARMED;
      end
      default: meas_d = DISARMED;
    endcase
  end

  // Publish measurement results with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= load;
      if (load) begin
        high_cnt   <= high_latch;
        period_cnt <= cnt;
      end
    end
  end

  // Duty level: count thresholds t with 16*high >= t*period (shift-add only).
  always_comb begin
    lvl      = 3'd0;
    prod     = '0;
    high_x16 = {high_cnt, 4'b0000};
    per_ext  = {4'b0000, period_cnt};
    for (int t = 0; t < N_THR; t++) begin
      prod = '0;
      for (int b = 0; b < 4; b++)
        if (THRESHOLDS[t][b]) prod = prod + (per_ext << b);
      if (high_x16 >= prod) lvl = lvl + 3'd1;
    end
  end

  // Timeout flag: set when idle hits the limit, cleared by the next rise.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      timeout <= 1'b0;
    else if (rise)
      timeout <= 1'b0;
    else if (timeout_hit)
      timeout <= 1'b1;
  end

  // Fan level: follows the new measurement, or the stuck level on timeout.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      state <= S_IDLE;
    else if (timeout_hit)
      state <= level ? S_7 : S_IDLE;
    else if (meas_valid)
      state <= level_onehot(lvl);
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (W=10, TIMEOUT_CYC=3000). Expected
// values are computed by hand from the PWM waveforms driven below.
module tb_pwm_capture;

  localparam int W  = 10;
  localparam int TO = 3000;

  logic         clk = 1'b0;
  logic         reset_p = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_cnt, period_cnt;
  logic         meas_valid, timeout;
  logic [7:0]   state;

  int total = 0;
  int bad   = 0;

  // Monitor results (written only by the monitor process).
  int           valid_cnt  = 0;
  logic [31:0]  last_h     = '0;
  logic [31:0]  last_p     = '0;
  logic [7:0]   last_state = '0;
  logic         mv_d       = 1'b0;
  int           base;

  pwm_capture #(.SYS_FREQ(125), .W(W), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .state      (state),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Sample outputs on the falling edge: record every measurement and the
  // fan level one cycle after it.
  always @(negedge clk) begin
    if (mv_d) last_state = state;
    if (meas_valid) begin
      valid_cnt = valid_cnt + 1;
      last_h    = 32'(high_cnt);
      last_p    = 32'(period_cnt);
    end
    mv_d = meas_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    wait_clk(n);
  endtask

  task automatic run_pwm(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic do_reset();
    pwm_in  = 1'b0;
    reset_p = 1'b1;
    wait_clk(5);
    reset_p = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    wait_clk(1);
    do_reset();

    // Reset values
    check("rst_high", 32'(high_cnt), 0);
    check("rst_period", 32'(period_cnt), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_state", 32'(state), 32'h01);

    // High 3 / period 8: 16*3=48 >= 8,40 -> L=2
    base = valid_cnt;
    run_pwm(3, 8, 4);
    check("p8_nvalid", valid_cnt - base, 3);
    check("p8_high", last_h, 3);
    check("p8_period", last_p, 8);
    check("p8_state", 32'(last_state), 32'h04);

    // Equality boundary: 16*5 == 5*16 -> L=2
    do_reset();
    base = valid_cnt;
    run_pwm(5, 16, 4);
    check("eq_nvalid", valid_cnt - base, 3);
    check("eq_high", last_h, 5);
    check("eq_period", last_p, 16);
    check("eq_state", 32'(last_state), 32'h04);

    // 25 % duty -> S_1
    do_reset();
    base = valid_cnt;
    run_pwm(250, 1000, 3);
    check("d25_nvalid", valid_cnt - base, 2);
    check("d25_high", last_h, 250);
    check("d25_period", last_p, 1000);
    check("d25_state", 32'(state), 32'h02);

    // 50 % duty -> S_3, then 87.5 % -> S_6
    do_reset();
    base = valid_cnt;
    run_pwm(500, 1000, 3);
    check("d50_high", last_h, 500);
    check("d50_state", 32'(state), 32'h08);
    run_pwm(875, 1000, 2);
    check("d875_nvalid", valid_cnt - base, 4);
    check("d875_high", last_h, 875);
    check("d875_state", 32'(last_state), 32'h40);

    // Timeout with input low (last pin change was 125 clocks ago)
    wait_clk(TO - 10 - 125);
    check("to_low_early", 32'(timeout), 0);
    wait_clk(30);
    check("to_low_flag", 32'(timeout), 1);
    check("to_low_state", 32'(state), 32'h01);
    check("to_low_hold_h", 32'(high_cnt), 875);
    check("to_low_hold_p", 32'(period_cnt), 1000);

    // Rise clears timeout without a measurement, then timeout with input high
    base = valid_cnt;
    drive(1'b1, 20);
    check("to_clr1", 32'(timeout), 0);
    check("to_clr1_nvalid", valid_cnt - base, 0);
    wait_clk(TO + 30);
    check("to_high_flag", 32'(timeout), 1);
    check("to_high_state", 32'(state), 32'h80);
    drive(1'b0, 10);
    check("to_fall_keeps", 32'(timeout), 1);
    drive(1'b1, 20);
    check("to_clr2", 32'(timeout), 0);
    check("to_clr2_nvalid", valid_cnt - base, 0);
    drive(1'b1, 230);
    drive(1'b0, 750);
    drive(1'b1, 10);
    check("rearm_nvalid", valid_cnt - base, 1);
    check("rearm_high", last_h, 250);
    check("rearm_period", last_p, 1000);

    // Reset in the middle of a high phase
    do_reset();
    run_pwm(250, 1000, 2);
    drive(1'b1, 100);
    reset_p = 1'b1;
    #2;
    check("midrst_high", 32'(high_cnt), 0);
    check("midrst_period", 32'(period_cnt), 0);
    check("midrst_valid", 32'(meas_valid), 0);
    check("midrst_timeout", 32'(timeout), 0);
    check("midrst_state", 32'(state), 32'h01);
    pwm_in = 1'b0;
    wait_clk(5);
    reset_p = 1'b0;
    drive(1'b0, 600);
    base = valid_cnt;
    run_pwm(250, 1000, 1);
    check("midrst_first_rise", valid_cnt - base, 0);
    run_pwm(250, 1000, 1);
    check("midrst_second", valid_cnt - base, 1);
    check("midrst_second_h", last_h, 250);

    // Saturation: period longer than 2^W-1 clocks
    do_reset();
    base = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 100);
    drive(1'b1, 250);
    drive(1'b0, 1300);
    drive(1'b1, 5);
    drive(1'b0, 20);
    check("sat_nvalid", valid_cnt - base, 2);
    check("sat_period", last_p, 1023);
    check("sat_high", last_h, 250);
    check("sat_state", 32'(last_state), 32'h02);

    // Two-clock low glitch inside a 500-clock high phase
    do_reset();
    base = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 200);
      drive(1'b0, 2);
      drive(1'b1, 298);
      drive(1'b0, 500);
    end
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("glitch_nvalid", valid_cnt - base, 2);
    check("glitch_high", last_h, 500);
    check("glitch_period", last_p, 1000);
`else
    check("glitch_nvalid", valid_cnt - base, 5);
    check("glitch_high", last_h, 200);
    check("glitch_period", last_p, 202);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
